pci_master: RTL and testbench
=============================

PCI_MASTER -- requirements
Module: pci_master

Interface
REQ-001 Parameter DEVSEL_TIMEOUT, default 5, number of data-phase clocks without DEVSEL# before a master abort.
REQ-002 Parameter MAX_RETRY, default 16, number of target retries tolerated before the transfer is reported as failed.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid/req_ready  in/out  1/1  local request handshake.
REQ-006 req_write, req_addr, req_data, req_be  in  1/32/32/4  direction, DWORD address, write data, active-high byte enables.
REQ-007 rsp_valid  out  1  one-clock response strobe.
REQ-008 rsp_data, rsp_status, rsp_perr  out  32/2/1  read data, completion status, read parity error.
REQ-009 ad_in/ad_out/ad_en, cbe_out/cbe_en, par_in/par_out/par_en  in/out/out  32/4/1  multiplexed AD, C/BE#, PAR pads.
REQ-010 frame_in/frame_out/frame_en, irdy_in/irdy_out/irdy_en  in/out/out  1  FRAME#, IRDY# pads, active-low.
REQ-011 trdy_in, stop_in, devsel_in  in  1  target responses, active-low.
REQ-012 req out 1, gnt in 1  arbitration REQ#/GNT#, active-low.

Function
REQ-013 States IDLE, ARB, ADDR, DATA, TURN, RESP; one transfer (single data phase) at a time.
REQ-014 req_ready SHALL be 1 only in IDLE; req_valid&req_ready latches all request fields and enters ARB.
REQ-015 ARB: req=0; enter ADDR the clock after gnt=0 AND frame_in=1 AND irdy_in=1 sampled together.
REQ-016 ADDR (1 clock): frame_out=0, ad_out=latched addr (bits 1:0 = 00), cbe_out=0110 read / 0111 write, frame_en=ad_en=cbe_en=1, req=1.
REQ-017 DATA: frame_out=1, irdy_out=0, irdy_en=1, cbe_out=~req_be; write drives ad_out=data with ad_en=1; read sets ad_en=0.
REQ-018 par_out = XOR of ad_out and cbe_out from the previous clock; par_en = ad_en delayed one clock.
REQ-019 DATA exit on trdy_in=0: status OK(00); read captures ad_in into rsp_data; trdy_in=0 with stop_in=0 also OK.
REQ-020 stop_in=0, trdy_in=1, devsel_in=0: retry; retry count increments.
REQ-021 stop_in=0, devsel_in=1 after DEVSEL# was seen in this data phase: TARGET_ABORT(10).
REQ-022 devsel_in=1 for DEVSEL_TIMEOUT consecutive DATA clocks: MASTER_ABORT(01).
REQ-023 TURN (1 clock): irdy_out=1, irdy_en=1, frame_en=0, ad_en=0, cbe_en=0; read checks par_in against XOR(captured ad_in, cbe_out) -> rsp_perr.
REQ-024 After TURN: retry with count < MAX_RETRY -> ARB; otherwise RESP.
REQ-025 Retry count reaching MAX_RETRY: status RETRY_EXCEEDED(11).
REQ-026 RESP (1 clock): rsp_valid=1; rsp_data and rsp_status hold until the next RESP; then IDLE.
REQ-027 gnt deasserted while in ARB: remain in ARB, req stays 0.
REQ-028 rsp_perr SHALL be 0 for writes and aborted reads.

Reset
REQ-029 rst SHALL force IDLE from any state on the next edge, including mid-transaction.
REQ-030 Reset values: all *_en=0, req=1, frame_out=irdy_out=1, rsp_valid=0, rsp_data=0, rsp_status=00, rsp_perr=0, retry count=0.

Structure
REQ-031 Shared package pci_pkg: command codes (MEM_READ, MEM_WRITE), status enum, state enum.
REQ-032 One sub-module pci_parity (combinational 36-bit XOR), reused for PAR generation and checking.

Verification
REQ-033 Write 0x1000_0040, data 0xDEADBEEF, be 1111; target asserts DEVSEL#+TRDY# in clock 2 of DATA -> C/BE 0111 in ADDR, 0000 in DATA, OK, rsp_valid after TURN.
REQ-034 Read 0x2000_0000, target returns 0x12345678 with correct PAR -> rsp_data 0x12345678, OK, rsp_perr=0; same with PAR flipped -> rsp_perr=1.
REQ-035 No target responds -> MASTER_ABORT after exactly 5 DATA clocks.
REQ-036 Target retries 3 times then TRDY# -> 4 ADDR phases, OK; retries always -> RETRY_EXCEEDED after 16 attempts.
REQ-037 DEVSEL# then STOP# with DEVSEL# deasserted -> TARGET_ABORT.
REQ-038 rst during DATA -> next clock all enables 0, req=1, req_ready=1; a subsequent request completes normally.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI single-data-phase bus master.
//   - bus command codes driven on C/BE# during the address phase
//   - completion status codes reported on rsp_status
//   - master FSM state encoding
package pci_pkg;

   localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
   localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

   typedef enum logic [1:0] {
      STAT_OK             = 2'b00,
      STAT_MASTER_ABORT   = 2'b01,
      STAT_TARGET_ABORT   = 2'b10,
      STAT_RETRY_EXCEEDED = 2'b11
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_ADDR,
      S_DATA,
      S_TURN,
      S_RESP
   } state_e;

endpackage : pci_pkg

// File: rtl/pci_parity.sv
// PCI even parity over one AD/C-BE# phase.
//   ad  : 32-bit AD value of the phase
//   cbe : 4-bit C/BE# value of the phase
//   par : PAR bit that makes the 37-bit total contain an even number of ones
module pci_parity (
   input  logic [31:0] ad,
   input  logic [3:0]  cbe,
   output logic        par
);

   assign par = ^{ad, cbe};

endmodule : pci_parity

// File: rtl/pci_master.sv
// PCI bus master performing one single-data-phase memory read or write per
// local request.
//   Local side : req_valid/req_ready request handshake with write flag,
//                DWORD address, write data and active-high byte enables;
//                rsp_valid one-clock strobe with rsp_data, rsp_status, rsp_perr.
//   PCI side   : AD, C/BE#, PAR, FRAME#, IRDY# pads as in/out/enable triples,
//                TRDY#/STOP#/DEVSEL# target inputs, REQ#/GNT# arbitration.
//   Parameters : DEVSEL_TIMEOUT data clocks without DEVSEL# before master
//                abort; MAX_RETRY target retries before giving up.
module pci_master
   import pci_pkg::*;
#(
   parameter int DEVSEL_TIMEOUT = 5,
   parameter int MAX_RETRY      = 16
) (
   input  logic        clk,
   input  logic        rst,
   // local request
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [3:0]  req_be,
   // local response
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_status,
   output logic        rsp_perr,
   // PCI pads
   input  logic [31:0] ad_in,
   output logic [31:0] ad_out,
   output logic        ad_en,
   output logic [3:0]  cbe_out,
   output logic        cbe_en,
   input  logic        par_in,
   output logic        par_out,
   output logic        par_en,
   input  logic        frame_in,
   output logic        frame_out,
   output logic        frame_en,
   input  logic        irdy_in,
   output logic        irdy_out,
   output logic        irdy_en,
   input  logic        trdy_in,
   input  logic        stop_in,
   input  logic        devsel_in,
   output logic        req,
   input  logic        gnt
);

   localparam int RETRY_W = $clog2(MAX_RETRY + 1);
   localparam int DSEL_W  = $clog2(DEVSEL_TIMEOUT + 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
   localparam logic [DSEL_W-1:0]  DSEL_LAST   = DSEL_W'(DEVSEL_TIMEOUT - 1);

   state_e               state_q,       state_d;
   logic                 write_q,       write_d;
   logic [31:2]          addr_q,        addr_d;
   logic [31:0]          data_q,        data_d;
   logic [3:0]           be_q,          be_d;
   logic [RETRY_W-1:0]   retry_cnt_q,   retry_cnt_d;
   logic                 retry_flag_q,  retry_flag_d;
   logic [DSEL_W-1:0]    dsel_cnt_q,    dsel_cnt_d;
   logic                 dsel_seen_q,   dsel_seen_d;
   status_e              outcome_q,     outcome_d;
   logic [31:0]          rdata_q,       rdata_d;
   logic [31:0]          rsp_data_q,    rsp_data_d;
   status_e              rsp_status_q,  rsp_status_d;
   logic                 rsp_perr_q,    rsp_perr_d;
   logic                 par_q,         par_d;
   logic                 par_en_q,      par_en_d;

   logic [RETRY_W-1:0]   retry_inc;
   logic                 par_gen;
   logic                 par_chk;
   logic [3:0]           be_n;
   logic                 addr_lsb_unused;

   // Addresses are DWORD aligned; the two low request bits are ignored.
   assign addr_lsb_unused = ^req_addr[1:0];
   assign retry_inc       = retry_cnt_q + 1'b1;
   assign be_n            = ~be_q;

   // PAR trails its AD/C-BE# phase by one clock: generate from what is on the
   // pads now, register, and present it the following clock.
   pci_parity u_par_gen (
      .ad  (ad_out),
      .cbe (cbe_out),
      .par (par_gen)
   );

   // Read data parity is checked against the byte enables of the data phase.
   pci_parity u_par_chk (
      .ad  (rdata_q),
      .cbe (be_n),
      .par (par_chk)
   );

   // NOTE: state flops take non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         write_q      <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         be_q         <= '0;
         retry_cnt_q  <= '0;
         retry_flag_q <= 1'b0;
         dsel_cnt_q   <= '0;
         dsel_seen_q  <= 1'b0;
         outcome_q    <= STAT_OK;
         rdata_q      <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= STAT_OK;
         rsp_perr_q   <= 1'b0;
         par_q        <= 1'b0;
         par_en_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         be_q         <= be_d;
         retry_cnt_q  <= retry_cnt_d;
         retry_flag_q <= retry_flag_d;
         dsel_cnt_q   <= dsel_cnt_d;
         dsel_seen_q  <= dsel_seen_d;
         outcome_q    <= outcome_d;
         rdata_q      <= rdata_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
         rsp_perr_q   <= rsp_perr_d;
         par_q        <= par_d;
         par_en_q     <= par_en_d;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      // NOTE: every variable gets a hold/default value first so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d      = state_q;
      write_d      = write_q;
      addr_d       = addr_q;
      data_d       = data_q;
      be_d         = be_q;
      retry_cnt_d  = retry_cnt_q;
      retry_flag_d = retry_flag_q;
      dsel_cnt_d   = dsel_cnt_q;
      dsel_seen_d  = dsel_seen_q;
      outcome_d    = outcome_q;
      rdata_d      = rdata_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      rsp_perr_d   = rsp_perr_q;
      par_d        = par_gen;
      par_en_d     = ad_en;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d     = req_write;
               addr_d      = req_addr[31:2];
               data_d      = req_data;
               be_d        = req_be;
               retry_cnt_d = '0;
               state_d     = S_ARB;
            end
         end

         S_ARB: begin
            // Granted and the bus is idle (no FRAME#, no IRDY# from anyone).
            if (!gnt && frame_in && irdy_in) begin
               state_d = S_ADDR;
            end
         end

         S_ADDR: begin
            dsel_cnt_d   = '0;
            dsel_seen_d  = 1'b0;
            retry_flag_d = 1'b0;
            outcome_d    = STAT_OK;
            state_d      = S_DATA;
         end

         S_DATA: begin
            state_d = S_TURN;
            if (!trdy_in) begin
               // Data transferred; STOP# alongside TRDY# is a normal disconnect.
               outcome_d = STAT_OK;
               if (!write_q) begin
                  rdata_d = ad_in;
               end
            end else if (!stop_in && !devsel_in) begin
               retry_cnt_d  = retry_inc;
               retry_flag_d = 1'b1;
               outcome_d    = (retry_inc >= RETRY_LIMIT) ? STAT_RETRY_EXCEEDED : STAT_OK;
            end else if (!stop_in && dsel_seen_q) begin
               outcome_d = STAT_TARGET_ABORT;
            end else if (devsel_in && (dsel_cnt_q == DSEL_LAST)) begin
               outcome_d = STAT_MASTER_ABORT;
            end else begin
               state_d = S_DATA;
               if (devsel_in) begin
                  dsel_cnt_d = dsel_cnt_q + 1'b1;
               end else begin
                  // The timeout counts consecutive clocks without DEVSEL#.
                  dsel_cnt_d  = '0;
                  dsel_seen_d = 1'b1;
               end
            end
         end

         S_TURN: begin
            if (retry_flag_q && (retry_cnt_q < RETRY_LIMIT)) begin
               state_d = S_ARB;
            end else begin
               state_d      = S_RESP;
               rsp_status_d = outcome_q;
               // Only a completed read reports data and parity; par_in carries
               // PAR for the read data phase during this clock.
               if (!write_q && (outcome_q == STAT_OK)) begin
                  rsp_data_d = rdata_q;
                  rsp_perr_d = (par_in != par_chk);
               end else begin
                  rsp_perr_d = 1'b0;
               end
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Pad and handshake outputs, decoded from the current state.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      req       = 1'b1;
      frame_out = 1'b1;
      frame_en  = 1'b0;
      irdy_out  = 1'b1;
      irdy_en   = 1'b0;
      ad_out    = '0;
      ad_en     = 1'b0;
      cbe_out   = '0;
      cbe_en    = 1'b0;

      case (state_q)
         S_IDLE: req_ready = 1'b1;
         S_ARB:  req       = 1'b0;
         S_ADDR: begin
            frame_out = 1'b0;
            frame_en  = 1'b1;
            irdy_en   = 1'b1;
            ad_out    = {addr_q, 2'b00};
            ad_en     = 1'b1;
            cbe_out   = write_q ? CMD_MEM_WRITE : CMD_MEM_READ;
            cbe_en    = 1'b1;
         end
         S_DATA: begin
            // Single data phase: FRAME# is already deasserted here.
            frame_en = 1'b1;
            irdy_out = 1'b0;
            irdy_en  = 1'b1;
            cbe_out  = be_n;
            cbe_en   = 1'b1;
            if (write_q) begin
               ad_out = data_q;
               ad_en  = 1'b1;
            end
         end
         S_TURN: irdy_en   = 1'b1;
         S_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign par_out    = par_q;
   assign par_en     = par_en_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_status = rsp_status_q;
   assign rsp_perr   = rsp_perr_q;

endmodule : pci_master

// File: tb/tb_pci_master.sv
module tb_pci_master;

   typedef enum int {T_OK, T_NONE, T_RETRY_ALL, T_TABORT} tmode_e;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      tmode_e      mode;
      int          resp_clk;
      int          retries;
      logic [31:0] rdata;
      logic        flip;
      logic [1:0]  exp_status;
      logic [31:0] exp_data;
      logic        chk_data;
      logic        exp_perr;
      int          exp_addr_phases;
      int          exp_data_clocks;
      logic [3:0]  exp_addr_cbe;
      logic [3:0]  exp_data_cbe;
      logic [31:0] exp_addr_ad;
   } vec_t;

   typedef struct {
      logic        got_rsp;
      logic [1:0]  status;
      logic [31:0] data;
      logic        perr;
      int          addr_phases;
      int          data_clocks;
      logic [3:0]  addr_cbe;
      logic [3:0]  data_cbe;
      logic [31:0] addr_ad;
      logic        addr_par;
      logic        addr_par_en;
      logic [31:0] data_ad;
      logic        data_ad_en;
      logic        turn_ok;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_data;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_status;
   logic        rsp_perr;
   logic [31:0] ad_in, ad_out;
   logic        ad_en;
   logic [3:0]  cbe_out;
   logic        cbe_en;
   logic        par_in, par_out, par_en;
   logic        frame_in, frame_out, frame_en;
   logic        irdy_in, irdy_out, irdy_en;
   logic        trdy_in, stop_in, devsel_in;
   logic        req, gnt;

   int checks = 0;
   int errors = 0;

   vec_t vecs[8];

   pci_master #(.DEVSEL_TIMEOUT(5), .MAX_RETRY(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_be     (req_be),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_status (rsp_status),
      .rsp_perr   (rsp_perr),
      .ad_in      (ad_in),
      .ad_out     (ad_out),
      .ad_en      (ad_en),
      .cbe_out    (cbe_out),
      .cbe_en     (cbe_en),
      .par_in     (par_in),
      .par_out    (par_out),
      .par_en     (par_en),
      .frame_in   (frame_in),
      .frame_out  (frame_out),
      .frame_en   (frame_en),
      .irdy_in    (irdy_in),
      .irdy_out   (irdy_out),
      .irdy_en    (irdy_en),
      .trdy_in    (trdy_in),
      .stop_in    (stop_in),
      .devsel_in  (devsel_in),
      .req        (req),
      .gnt        (gnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      gnt       = 1'b0;
      frame_in  = 1'b1;
      irdy_in   = 1'b1;
      trdy_in   = 1'b1;
      stop_in   = 1'b1;
      devsel_in = 1'b1;
      ad_in     = '0;
      par_in    = 1'b0;
   endtask

   task automatic issue_req(input vec_t v);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = v.write;
      req_addr  = v.addr;
      req_data  = v.wdata;
      req_be    = v.be;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Target model: answers each data phase according to v.mode and returns
   // what was seen on the bus until the response strobe.
   task automatic run_bus(input vec_t v, output obs_t o);
      int  k;
      bit  done;
      o = '{default: '0};
      k = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         if (cyc != 0) @(negedge clk);
         bus_idle();
         if (frame_en && !frame_out) begin
            o.addr_phases++;
            k = 0;
            o.addr_cbe = cbe_out;
            o.addr_ad  = ad_out;
         end else if (irdy_en && !irdy_out) begin
            k++;
            o.data_clocks++;
            if (k == 1) begin
               o.addr_par    = par_out;
               o.addr_par_en = par_en;
               o.data_ad     = ad_out;
               o.data_ad_en  = ad_en;
               o.data_cbe    = cbe_out;
            end
            case (v.mode)
               T_OK: begin
                  if (o.addr_phases > v.retries) begin
                     if (k >= v.resp_clk) begin
                        devsel_in = 1'b0;
                        trdy_in   = 1'b0;
                        ad_in     = v.rdata;
                     end
                  end else begin
                     devsel_in = 1'b0;
                     stop_in   = 1'b0;
                  end
               end
               T_RETRY_ALL: begin
                  devsel_in = 1'b0;
                  stop_in   = 1'b0;
               end
               T_TABORT: begin
                  if (k == 1) devsel_in = 1'b0;
                  else        stop_in   = 1'b0;
               end
               default: ;
            endcase
         end else if (irdy_en && irdy_out && !frame_en) begin
            o.turn_ok = !ad_en && !cbe_en;
            par_in = (^{v.rdata, ~v.be}) ^ v.flip;
         end else if (rsp_valid) begin
            o.status = rsp_status;
            o.data   = rsp_data;
            o.perr   = rsp_perr;
            done     = 1'b1;
         end
      end
      o.got_rsp = done;
   endtask

   task automatic check_obs(input string p, input vec_t v, input obs_t o);
      check({p, "_rsp_seen"},    32'(o.got_rsp), 32'd1);
      check({p, "_status"},      32'(o.status), 32'(v.exp_status));
      if (v.chk_data) check({p, "_rdata"}, o.data, v.exp_data);
      check({p, "_perr"},        32'(o.perr), 32'(v.exp_perr));
      check({p, "_addr_phases"}, o.addr_phases, v.exp_addr_phases);
      check({p, "_data_clocks"}, o.data_clocks, v.exp_data_clocks);
      check({p, "_addr_cbe"},    32'(o.addr_cbe), 32'(v.exp_addr_cbe));
      check({p, "_data_cbe"},    32'(o.data_cbe), 32'(v.exp_data_cbe));
      check({p, "_addr_ad"},     o.addr_ad, v.exp_addr_ad);
      check({p, "_addr_par_en"}, 32'(o.addr_par_en), 32'd1);
      check({p, "_addr_par"},    32'(o.addr_par), 32'(^{v.exp_addr_ad, v.exp_addr_cbe}));
      check({p, "_data_ad_en"},  32'(o.data_ad_en), 32'(v.write));
      if (v.write) check({p, "_data_ad"}, o.data_ad, v.wdata);
      check({p, "_turn_released"}, 32'(o.turn_ok), 32'd1);
      // Strobe lasts one clock, status holds, and the master is idle again.
      @(negedge clk);
      bus_idle();
      check({p, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
      check({p, "_ready_again"},    32'(req_ready), 32'd1);
      check({p, "_status_hold"},    32'(rsp_status), 32'(v.exp_status));
   endtask

   task automatic run_vec(input int i);
      obs_t o;
      issue_req(vecs[i]);
      run_bus(vecs[i], o);
      check_obs($sformatf("v%0d", i), vecs[i], o);
   endtask

   task automatic check_idle_pads(input string p);
      check({p, "_ad_en"},     32'(ad_en), 32'd0);
      check({p, "_cbe_en"},    32'(cbe_en), 32'd0);
      check({p, "_par_en"},    32'(par_en), 32'd0);
      check({p, "_frame_en"},  32'(frame_en), 32'd0);
      check({p, "_irdy_en"},   32'(irdy_en), 32'd0);
      check({p, "_req"},       32'(req), 32'd1);
      check({p, "_req_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      obs_t o;
      vec_t v;
      bit   seen;

      //          wr    addr          wdata         be       mode         rc rt rdata         fl  st     exp_data      cd pe ap  dc  acbe     dcbe     addr_ad
      vecs[0] = '{1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'b1111, T_OK,        2, 0, 32'h0,        1'b0, 2'b00, 32'h0,        1'b0, 1'b0, 1,  2, 4'b0111, 4'b0000, 32'h1000_0040};
      vecs[1] = '{1'b0, 32'h2000_0000, 32'h0,         4'b1111, T_OK,        1, 0, 32'h1234_5678, 1'b0, 2'b00, 32'h1234_5678, 1'b1, 1'b0, 1,  1, 4'b0110, 4'b0000, 32'h2000_0000};
      vecs[2] = '{1'b0, 32'h2000_0000, 32'h0,         4'b1111, T_OK,        1, 0, 32'h1234_5678, 1'b1, 2'b00, 32'h1234_5678, 1'b1, 1'b1, 1,  1, 4'b0110, 4'b0000, 32'h2000_0000};
      vecs[3] = '{1'b0, 32'h3000_0008, 32'h0,         4'b0011, T_NONE,      0, 0, 32'h0,        1'b1, 2'b01, 32'h0,        1'b0, 1'b0, 1,  5, 4'b0110, 4'b1100, 32'h3000_0008};
      vecs[4] = '{1'b1, 32'h4000_0004, 32'hA5A5_0F0F, 4'b0101, T_OK,        1, 3, 32'h0,        1'b0, 2'b00, 32'h0,        1'b0, 1'b0, 4,  4, 4'b0111, 4'b1010, 32'h4000_0004};
      vecs[5] = '{1'b0, 32'h5000_0100, 32'h0,         4'b1111, T_RETRY_ALL, 0, 0, 32'h0,        1'b0, 2'b11, 32'h0,        1'b0, 1'b0, 16, 16, 4'b0110, 4'b0000, 32'h5000_0100};
      vecs[6] = '{1'b0, 32'h6000_0020, 32'h0,         4'b1111, T_TABORT,    0, 0, 32'h0,        1'b1, 2'b10, 32'h0,        1'b0, 1'b0, 1,  2, 4'b0110, 4'b0000, 32'h6000_0020};
      vecs[7] = '{1'b0, 32'h7000_0007, 32'h0,         4'b1001, T_OK,        3, 0, 32'hCAFE_F00D, 1'b0, 2'b00, 32'hCAFE_F00D, 1'b1, 1'b0, 1,  3, 4'b0110, 4'b0110, 32'h7000_0004};

      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      req_be    = '0;
      bus_idle();
      repeat (3) @(negedge clk);

      // Reset state.
      check_idle_pads("reset");
      check("reset_frame_out", 32'(frame_out), 32'd1);
      check("reset_irdy_out",  32'(irdy_out), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data",  rsp_data, 32'd0);
      check("reset_rsp_status", 32'(rsp_status), 32'd0);
      check("reset_rsp_perr",  32'(rsp_perr), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(i);

      // Arbitration stall: GNT# withheld, then the bus still busy.
      v = vecs[1];
      v.addr        = 32'h0800_0010;
      v.exp_addr_ad = 32'h0800_0010;
      v.rdata       = 32'h0BAD_CAFE;
      v.exp_data    = 32'h0BAD_CAFE;
      issue_req(v);
      gnt = 1'b1;
      for (int c = 0; c < 4; c++) begin
         check($sformatf("arb_nognt_req_%0d", c),   32'(req), 32'd0);
         check($sformatf("arb_nognt_frame_%0d", c), 32'(frame_en), 32'd0);
         @(negedge clk);
      end
      gnt      = 1'b0;
      frame_in = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("arb_busbusy_frame_%0d", c), 32'(frame_en), 32'd0);
      end
      frame_in = 1'b1;
      run_bus(v, o);
      check_obs("arb_stall", v, o);

      // Reset in the middle of a data phase, then a normal transfer.
      issue_req(vecs[3]);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (irdy_en && !irdy_out) seen = 1'b1;
      end
      check("midrst_reached_data", 32'(seen), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_pads("midrst");
      run_vec(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pci_master
